// File: rtl/param_fifo_pkg.sv
// Shared constants, helpers and error-kind enum for the param_fifo family.
// The optional first-word fall-through mode is selected by PARAM_FIFO_FWFT_EN.
package param_fifo_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefAddrW = 4;

    typedef enum logic [1:0] {
        FIFO_OK,
        FIFO_OVF,
        FIFO_UDF
    } fifo_err_e;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer bundle for param_fifo; master drives requests, slave is the FIFO.
// Read-side timing depends on PARAM_FIFO_FWFT_EN in the FIFO build.
interface param_fifo_if
    import param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned ADDR_W = DefAddrW
) ();

    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic              clear_err;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clear_err,
        input  rd_data, rd_valid, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clear_err,
        output rd_data, rd_valid, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

endinterface

// File: rtl/param_fifo_mem.sv
// Dual-port storage for param_fifo: synchronous write, asynchronous read, no reset.
module param_fifo_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned Depth = 32'd1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with programmable almost flags and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for first-word fall-through reads; default is registered reads.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned AF_THRESH = fifo_depth(ADDR_W) - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input logic         clk,
    input logic         reset,
    param_fifo_if.slave bus
);

    localparam int unsigned Depth = fifo_depth(ADDR_W);

    typedef logic [ADDR_W:0] ptr_t;

    localparam ptr_t DepthP = ptr_t'(Depth);
    localparam ptr_t AfThr  = ptr_t'(AF_THRESH);
    localparam ptr_t AeThr  = ptr_t'(AE_THRESH);

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             empty, full;
    logic             wr_accept, rd_accept;
    logic [WIDTH-1:0] mem_rdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DepthP);
    assign wr_accept = bus.wr_en && !full;
    assign rd_accept = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + ptr_t'(wr_accept);
        rd_ptr_d    = rd_ptr_q + ptr_t'(rd_accept);
        count_d     = wr_ptr_d - rd_ptr_d;
        // A fresh error in the same cycle as clear_err must survive the clear.
        overflow_d  = overflow_q && !bus.clear_err;
        underflow_d = underflow_q && !bus.clear_err;
        if (bus.wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (bus.rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    param_fifo_mem #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

`ifdef PARAM_FIFO_FWFT_EN
    assign bus.rd_data  = mem_rdata;
    assign bus.rd_valid = !empty;
`else
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= AeThr);
    assign bus.almost_full  = (count_q >= AfThr);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
